spi_stream_arbiter: RTL and testbench
=====================================

Name: spi_stream_arbiter

Overview:
- Schedules SD-card block reads over the single SPI link, shared between the video frame stream and the audio sample stream.
- Sits between DATA_FSM's block-read engine and its consumers (video_top bank writes, audio FIFO).
- Decides which stream owns the next 512-byte block, generates sector addresses, and steers data via write_video/write_audio.
- Pulses frame_loaded into MODE_FSM switch_mode; throttles video until the bank swap completes.

Parameters:
- FRAME_BLOCKS, 20, SD blocks per video frame
- VIDEO_BASE, 32'h0000_0800, first video sector
- VIDEO_BLOCKS, 131480, total video sectors (6574 frames x 20)
- AUDIO_BASE, 32'h0010_0000, first audio sector
- AUDIO_BLOCKS, 8800, total audio sectors
- LVL_W, 12, audio FIFO level width (bytes)
- AUDIO_FILL, 1536, audio pending when level <= this
- AUDIO_URGENT, 256, audio urgent when level <= this
- MAX_RETRY, 3, retries of a failed block before fault

Ports:
- CLK_40  in  1  40 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- init  in  1  start pulse after SD init; ignored unless in IDLE
- bank_swapped  in  1  one-cycle pulse from MODE_FSM: write bank released
- audio_level  in  LVL_W  audio FIFO fill level, bytes
- rd_req  out  1  block-read request to SPI engine
- rd_addr  out  32  sector address, valid while rd_req high
- rd_ack  in  1  engine accepted request
- rd_done  in  1  block transfer complete pulse
- rd_err  in  1  block failed pulse (CRC/timeout)
- write_video  out  1  route incoming bytes to video bank
- write_audio  out  1  route incoming bytes to audio FIFO
- frame_loaded  out  1  pulse: full frame in write bank
- stream_end  out  1  level: both streams exhausted
- fault  out  1  level: retry limit exceeded
- busy  out  1  block transfer in progress

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; rd_addr=0; counters 0; vid_hold=0; retry=0; last_grant=audio (video wins first tie).
- States: IDLE, ARB, ISSUE, XFER, DONE, FAULT.
- IDLE: init=1 -> ARB next cycle.
- Pending terms:
  - vid_pend = !vid_hold && vid_cnt<VIDEO_BLOCKS
  - aud_pend = audio_level<=AUDIO_FILL && aud_cnt<AUDIO_BLOCKS
  - aud_urg = aud_pend && audio_level<=AUDIO_URGENT
- ARB (one cycle per decision):
  - aud_urg -> audio.
  - Else if both pending -> stream != last_grant.
  - Else -> whichever is pending.
  - Neither pending and both counts exhausted -> DONE; otherwise stay in ARB.
  - Latch grant, last_grant, rd_addr = base + cnt -> ISSUE.
- ISSUE:
  - rd_req=1, rd_addr stable; write_video/write_audio=1 per grant, busy=1.
  - Hold until rd_ack; rd_req drops the cycle after rd_ack -> XFER.
- XFER: steering and busy held.
  - rd_err (wins if coincident with rd_done): retry<MAX_RETRY -> retry++, same address -> ISSUE; else -> FAULT.
  - rd_done: retry=0; increment granted count; steering and busy drop next cycle -> ARB.
  - Video done: frame_blk++; when it reaches FRAME_BLOCKS -> frame_blk=0, frame_loaded pulses 1 cycle after rd_done, vid_hold=1.
- vid_hold: cleared by bank_swapped. bank_swapped with vid_hold=0 is ignored. Coincident set and clear: set wins.
- Last video block that completes a partial frame still asserts frame_loaded.
- DONE: stream_end=1, sticky until reset. FAULT: fault=1, sticky, rd_req=0, steering 0.
- Exactly one of write_video/write_audio is high at a time; never both.
- Counters never wrap: an exhausted stream is never granted.
- init outside IDLE ignored. audio_level sampled only in ARB.

Test Plan:
- Reset, init, audio_level=2048 -> 20 video reads at sectors 0x800..0x813, rd_req held until rd_ack; frame_loaded pulses once after 20th rd_done; no further rd_req until bank_swapped; then sector 0x814.
- audio_level=1000 with video pending -> grants alternate video, audio, video; audio addresses 0x100000, 0x100001.
- audio_level=100 with video pending, last grant audio -> audio still granted (urgent overrides round-robin).
- rd_err twice then rd_done on sector 0x805 -> three rd_req at 0x805, next read 0x806, fault=0; four consecutive rd_err -> fault=1, rd_req stays 0.
- VIDEO_BLOCKS=40, AUDIO_BLOCKS=2 -> after 40 video + 2 audio dones, stream_end=1, no further rd_req despite bank_swapped or low audio_level.
- reset_n low mid-XFER -> all outputs 0 immediately; after release plus init, first read is 0x800 again.

Source files
------------

// File: rtl/spi_stream_arbiter.sv
// Shares the SD-card SPI block-read engine between the video frame stream and the
// audio sample stream: picks the owner of each block, generates sectors, steers data.
module spi_stream_arbiter #(
  parameter int unsigned FRAME_BLOCKS = 20,
  parameter logic [31:0] VIDEO_BASE   = 32'h0000_0800,
  parameter int unsigned VIDEO_BLOCKS = 131480,
  parameter logic [31:0] AUDIO_BASE   = 32'h0010_0000,
  parameter int unsigned AUDIO_BLOCKS = 8800,
  parameter int unsigned LVL_W        = 12,
  parameter int unsigned AUDIO_FILL   = 1536,
  parameter int unsigned AUDIO_URGENT = 256,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic             CLK_40,
  input  logic             reset_n,
  input  logic             init,
  input  logic             bank_swapped,
  input  logic [LVL_W-1:0] audio_level,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic             rd_ack,
  input  logic             rd_done,
  input  logic             rd_err,
  output logic             write_video,
  output logic             write_audio,
  output logic             frame_loaded,
  output logic             stream_end,
  output logic             fault,
  output logic             busy
);

  localparam int VC_W = $clog2(VIDEO_BLOCKS + 1);
  localparam int AC_W = $clog2(AUDIO_BLOCKS + 1);
  localparam int FB_W = $clog2(FRAME_BLOCKS + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [VC_W-1:0]  VID_MAX  = VC_W'(VIDEO_BLOCKS);
  localparam logic [VC_W-1:0]  VID_LAST = VC_W'(VIDEO_BLOCKS - 1);
  localparam logic [AC_W-1:0]  AUD_MAX  = AC_W'(AUDIO_BLOCKS);
  localparam logic [FB_W-1:0]  FB_LAST  = FB_W'(FRAME_BLOCKS - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [LVL_W-1:0] FILL_LVL = LVL_W'(AUDIO_FILL);
  localparam logic [LVL_W-1:0] URG_LVL  = LVL_W'(AUDIO_URGENT);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_XFER, S_DONE, S_FAULT} state_t;

  state_t          state, state_nxt;
  logic [VC_W-1:0] vid_cnt;
  logic [AC_W-1:0] aud_cnt;
  logic [FB_W-1:0] frame_blk;
  logic [RT_W-1:0] retry;
  logic            vid_hold, grant_vid, last_vid;
  logic            vid_pend, aud_pend, aud_urg, vid_exh, aud_exh;
  logic            arb_go, pick_vid, vid_done, frame_end;

  assign vid_exh  = (vid_cnt == VID_MAX);
  assign aud_exh  = (aud_cnt == AUD_MAX);
  assign vid_pend = !vid_hold && !vid_exh;
  assign aud_pend = (audio_level <= FILL_LVL) && !aud_exh;
  assign aud_urg  = aud_pend && (audio_level <= URG_LVL);

  // A clean video completion; a frame also ends on the very last video sector
  assign vid_done  = (state == S_XFER) && rd_done && !rd_err && grant_vid;
  assign frame_end = vid_done && ((frame_blk == FB_LAST) || (vid_cnt == VID_LAST));

  always_comb begin
    state_nxt = state;
    arb_go    = 1'b0;
    pick_vid  = 1'b0;
    case (state)
      S_IDLE:  if (init) state_nxt = S_ARB;
      S_ARB: begin
        if (aud_urg) begin
          arb_go = 1'b1;
        end else if (vid_pend && aud_pend) begin
          arb_go   = 1'b1;
          pick_vid = !last_vid;
        end else if (vid_pend) begin
          arb_go   = 1'b1;
          pick_vid = 1'b1;
        end else if (aud_pend) begin
          arb_go = 1'b1;
        end else if (vid_exh && aud_exh) begin
          state_nxt = S_DONE;
        end
        if (arb_go) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (rd_ack) state_nxt = S_XFER;
      S_XFER: begin
        if (rd_err)       state_nxt = (retry < RT_MAX) ? S_ISSUE : S_FAULT;
        else if (rd_done) state_nxt = S_ARB;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      vid_cnt      <= '0;
      aud_cnt      <= '0;
      frame_blk    <= '0;
      retry        <= '0;
      vid_hold     <= 1'b0;
      grant_vid    <= 1'b0;
      last_vid     <= 1'b0;
      rd_addr      <= '0;
      frame_loaded <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_loaded <= frame_end;
      if (frame_end)         vid_hold <= 1'b1;
      else if (bank_swapped) vid_hold <= 1'b0;
      if (state == S_ARB && arb_go) begin
        grant_vid <= pick_vid;
        last_vid  <= pick_vid;
        rd_addr   <= pick_vid ? VIDEO_BASE + 32'(vid_cnt) : AUDIO_BASE + 32'(aud_cnt);
      end
      if (state == S_XFER) begin
        if (rd_err) begin
          if (retry < RT_MAX) retry <= retry + 1'b1;
        end else if (rd_done) begin
          retry <= '0;
          if (grant_vid) begin
            vid_cnt   <= vid_cnt + 1'b1;
            frame_blk <= (frame_blk == FB_LAST) ? '0 : frame_blk + 1'b1;
          end else begin
            aud_cnt <= aud_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign rd_req      = (state == S_ISSUE);
  assign busy        = (state == S_ISSUE) || (state == S_XFER);
  assign write_video = busy && grant_vid;
  assign write_audio = busy && !grant_vid;
  assign stream_end  = (state == S_DONE);
  assign fault       = (state == S_FAULT);

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// Directed bench for spi_stream_arbiter, built with small stream lengths
// (40 video, 2 audio sectors) so exhaustion is reachable.
module tb_spi_stream_arbiter;

  logic        CLK_40, reset_n, init, bank_swapped, rd_ack, rd_done, rd_err;
  logic [11:0] audio_level;
  logic        rd_req, write_video, write_audio, frame_loaded, stream_end, fault, busy;
  logic [31:0] rd_addr;
  int          n_chk, n_fail;

  spi_stream_arbiter #(.VIDEO_BLOCKS(40), .AUDIO_BLOCKS(2)) dut (
    .CLK_40(CLK_40), .reset_n(reset_n), .init(init), .bank_swapped(bank_swapped),
    .audio_level(audio_level), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_done(rd_done), .rd_err(rd_err), .write_video(write_video),
    .write_audio(write_audio), .frame_loaded(frame_loaded), .stream_end(stream_end),
    .fault(fault), .busy(busy)
  );

  initial CLK_40 = 1'b0;
  always #5 CLK_40 = ~CLK_40;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start(input logic [11:0] lvl);
    reset_n = 1'b0; init = 1'b0; bank_swapped = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0; rd_err = 1'b0; audio_level = lvl;
    repeat (2) @(negedge CLK_40);
    reset_n = 1'b1;
    @(negedge CLK_40); init = 1'b1;
    @(negedge CLK_40); init = 1'b0;
  endtask

  // Serve one block request: expect addr/steering, ack after ack_dly, then done or err
  task automatic do_block(input logic [31:0] addr, input logic vid, input int ack_dly,
                          input logic err, input logic exp_fl);
    int t;
    t = 0;
    while (rd_req !== 1'b1 && t < 50) begin
      @(negedge CLK_40); t++;
    end
    n_chk++;
    if (rd_req !== 1'b1) begin
      n_fail++; $display("FAIL req_timeout: rd_req=%b required 1 (addr %h)", rd_req, addr);
    end
    n_chk++;
    if (rd_addr !== addr) begin
      n_fail++; $display("FAIL rd_addr: got %h required %h", rd_addr, addr);
    end
    n_chk++;
    if ({write_video, write_audio, busy} !== {vid, !vid, 1'b1}) begin
      n_fail++; $display("FAIL steer_issue: got %b required %b",
                         {write_video, write_audio, busy}, {vid, !vid, 1'b1});
    end
    if (ack_dly > 0) begin
      repeat (ack_dly) @(negedge CLK_40);
      n_chk++;
      if (rd_req !== 1'b1 || rd_addr !== addr) begin
        n_fail++; $display("FAIL req_hold: rd_req=%b addr=%h required 1/%h", rd_req, rd_addr, addr);
      end
    end
    rd_ack = 1'b1;
    @(negedge CLK_40);
    rd_ack = 1'b0;
    n_chk++;
    if ({rd_req, write_video, write_audio, busy} !== {1'b0, vid, !vid, 1'b1}) begin
      n_fail++; $display("FAIL xfer_state: got %b required %b",
                         {rd_req, write_video, write_audio, busy}, {1'b0, vid, !vid, 1'b1});
    end
    if (err) rd_err = 1'b1;
    else     rd_done = 1'b1;
    @(negedge CLK_40);
    rd_err = 1'b0; rd_done = 1'b0;
    n_chk++;
    if (frame_loaded !== exp_fl) begin
      n_fail++; $display("FAIL frame_loaded: got %b required %b at %h", frame_loaded, exp_fl, addr);
    end
    if (!err) begin
      n_chk++;
      if ({write_video, write_audio, busy} !== 3'b000) begin
        n_fail++; $display("FAIL steer_release: got %b required 000", {write_video, write_audio, busy});
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; init = 1'b0; bank_swapped = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0; rd_err = 1'b0; audio_level = 12'd100;
    repeat (2) @(negedge CLK_40);
    n_chk++;
    if ({rd_req, write_video, write_audio, frame_loaded, stream_end, fault, busy} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0000000",
                         {rd_req, write_video, write_audio, frame_loaded, stream_end, fault, busy});
    end
    n_chk++;
    if (rd_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h required 00000000", rd_addr);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge CLK_40);
    n_chk++;
    if (rd_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_init: rd_req=%b required 0", rd_req);
    end
  endtask

  task automatic test_video_frame();
    logic seen;
    start(12'd2048);
    for (int i = 0; i < 20; i++)
      do_block(32'h800 + 32'(i), 1'b1, (i == 0) ? 3 : 0, 1'b0, i == 19);
    seen = 1'b0;
    @(negedge CLK_40);
    n_chk++;
    if (frame_loaded !== 1'b0) begin
      n_fail++; $display("FAIL frame_pulse_width: got %b required 0", frame_loaded);
    end
    repeat (10) begin
      if (rd_req) seen = 1'b1;
      @(negedge CLK_40);
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL video_hold: rd_req seen=%b required 0", seen);
    end
    bank_swapped = 1'b1;
    @(negedge CLK_40);
    bank_swapped = 1'b0;
    do_block(32'h814, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_alternate();
    start(12'd1000);
    do_block(32'h800, 1'b1, 0, 1'b0, 1'b0);
    do_block(32'h100000, 1'b0, 0, 1'b0, 1'b0);
    do_block(32'h801, 1'b1, 0, 1'b0, 1'b0);
    do_block(32'h100001, 1'b0, 1, 1'b0, 1'b0);
    do_block(32'h802, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_urgent();
    start(12'd100);
    do_block(32'h100000, 1'b0, 0, 1'b0, 1'b0);
    do_block(32'h100001, 1'b0, 0, 1'b0, 1'b0);
    do_block(32'h800, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_retry();
    logic seen;
    start(12'd2048);
    for (int i = 0; i < 5; i++) do_block(32'h800 + 32'(i), 1'b1, 0, 1'b0, 1'b0);
    do_block(32'h805, 1'b1, 0, 1'b1, 1'b0);
    do_block(32'h805, 1'b1, 0, 1'b1, 1'b0);
    do_block(32'h805, 1'b1, 0, 1'b0, 1'b0);
    do_block(32'h806, 1'b1, 0, 1'b0, 1'b0);
    n_chk++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_after_recovery: got %b required 0", fault);
    end
    for (int k = 0; k < 4; k++) do_block(32'h807, 1'b1, 0, 1'b1, 1'b0);
    n_chk++;
    if ({fault, rd_req, write_video, write_audio, busy} !== 5'b10000) begin
      n_fail++; $display("FAIL fault_state: got %b required 10000",
                         {fault, rd_req, write_video, write_audio, busy});
    end
    seen = 1'b0;
    repeat (10) begin
      if (rd_req || !fault) seen = 1'b1;
      @(negedge CLK_40);
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL fault_sticky: disturbance=%b required 0", seen);
    end
  endtask

  task automatic test_stream_end();
    logic seen;
    start(12'd2048);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        bank_swapped = 1'b1;
        @(negedge CLK_40);
        bank_swapped = 1'b0;
      end
      do_block(32'h800 + 32'(i), 1'b1, 0, 1'b0, (i == 19) || (i == 39));
    end
    bank_swapped = 1'b1;
    @(negedge CLK_40);
    bank_swapped = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (rd_req || stream_end) seen = 1'b1;
      @(negedge CLK_40);
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL video_exhausted: activity=%b required 0", seen);
    end
    audio_level = 12'd1000;
    do_block(32'h100000, 1'b0, 0, 1'b0, 1'b0);
    do_block(32'h100001, 1'b0, 0, 1'b0, 1'b0);
    @(negedge CLK_40);
    n_chk++;
    if (stream_end !== 1'b1) begin
      n_fail++; $display("FAIL stream_end: got %b required 1", stream_end);
    end
    bank_swapped = 1'b1; audio_level = 12'd100;
    @(negedge CLK_40);
    bank_swapped = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (rd_req || !stream_end) seen = 1'b1;
      @(negedge CLK_40);
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL stream_end_sticky: disturbance=%b required 0", seen);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    start(12'd2048);
    t = 0;
    while (rd_req !== 1'b1 && t < 50) begin
      @(negedge CLK_40); t++;
    end
    rd_ack = 1'b1;
    @(negedge CLK_40);
    rd_ack = 1'b0;
    n_chk++;
    if ({busy, write_video} !== 2'b11) begin
      n_fail++; $display("FAIL mid_xfer_busy: got %b required 11", {busy, write_video});
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({rd_req, write_video, write_audio, busy, rd_addr} !== 36'h0) begin
      n_fail++; $display("FAIL async_reset: got %b/%h required 0000/0",
                         {rd_req, write_video, write_audio, busy}, rd_addr);
    end
    @(negedge CLK_40);
    reset_n = 1'b1;
    @(negedge CLK_40); init = 1'b1;
    @(negedge CLK_40); init = 1'b0;
    do_block(32'h800, 1'b1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0;
    test_reset();
    test_video_frame();
    test_alternate();
    test_urgent();
    test_retry();
    test_stream_end();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
